// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer that drives an external combinational ALU: single pass for
// arithmetic/logic ops, repeated one-bit passes for logical shifts, then holds the result.
module alu_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    input  logic [4:0]  cmd_shamt,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_sel,
    input  logic [31:0] alu_out,
    input  logic        alu_overflow,
    input  logic        alu_carry,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [3:0]  rsp_flags,
    output logic        busy
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_SHR = 3'b010;
    localparam logic [2:0] OP_SHL = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] b_q, b_d;
    logic [31:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [3:0]  rsp_flags_q, rsp_flags_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        busy_q, busy_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [2:0]  alu_sel_q, alu_sel_d;
    logic        cmd_is_bitshift_s;

    function automatic logic is_zero(input logic [31:0] v);
        return (v == 32'h0000_0000);
    endfunction

    // {N,Z,V,C}: V only meaningful for add/sub, C only for add
    function automatic logic [3:0] exec_flags(input logic [2:0] op, input logic [31:0] res,
                                              input logic ovf, input logic carry);
        logic v_s;
        logic c_s;
        v_s = ((op == OP_ADD) || (op == OP_SUB)) ? ovf : 1'b0;
        c_s = (op == OP_ADD) ? carry : 1'b0;
        return {res[31], is_zero(res), v_s, c_s};
    endfunction

    assign cmd_is_bitshift_s = (cmd_op == OP_SHR) || (cmd_op == OP_SHL);

    // Next-state, datapath and next registered-output computation
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        b_d         = b_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d  = cmd_op;
                    b_d   = cmd_b;
                    acc_d = cmd_a;
                    if (cmd_is_bitshift_s && (cmd_shamt == 5'd0)) begin
                        state_d     = RESP;
                        cnt_d       = 5'd0;
                        rsp_data_d  = cmd_a;
                        rsp_flags_d = {cmd_a[31], is_zero(cmd_a), 2'b00};
                    end else begin
                        state_d = EXEC;
                        cnt_d   = cmd_is_bitshift_s ? cmd_shamt : 5'd1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                acc_d = alu_out;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d     = RESP;
                    rsp_data_d  = alu_out;
                    rsp_flags_d = exec_flags(op_q, alu_out, alu_overflow, alu_carry);
                end else begin
                    state_d = EXEC;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Outputs are registered, so derive them from the upcoming state
        rsp_valid_d = (state_d == RESP);
        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        alu_a_d     = (state_d == EXEC) ? acc_d : 32'h0000_0000;
        alu_b_d     = (state_d == EXEC) ? b_d   : 32'h0000_0000;
        alu_sel_d   = (state_d == EXEC) ? op_d  : 3'b000;
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= 3'b000;
            b_q         <= 32'h0000_0000;
            acc_q       <= 32'h0000_0000;
            cnt_q       <= 5'd0;
            rsp_data_q  <= 32'h0000_0000;
            rsp_flags_q <= 4'b0000;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            alu_a_q     <= 32'h0000_0000;
            alu_b_q     <= 32'h0000_0000;
            alu_sel_q   <= 3'b000;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
            rsp_valid_q <= rsp_valid_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_flags = rsp_flags_q;
    assign busy      = busy_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU that shifts one bit per pass
// for 010/011 and by B for 100.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'b000;
    logic [31:0] cmd_a = 32'h0;
    logic [31:0] cmd_b = 32'h0;
    logic [4:0]  cmd_shamt = 5'd0;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_sel;
    logic [31:0] alu_out;
    logic        alu_overflow;
    logic        alu_carry;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_flags;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shamt(cmd_shamt),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .alu_overflow(alu_overflow), .alu_carry(alu_carry), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_flags(rsp_flags), .busy(busy)
    );

    // Reference ALU (environment, not a model of the sequencer)
    always_comb begin
        logic [32:0] wide;
        wide         = 33'h0;
        alu_out      = 32'h0;
        alu_overflow = 1'b0;
        alu_carry    = 1'b0;
        case (alu_sel)
            3'b000: begin
                wide         = {1'b0, alu_a} + {1'b0, alu_b};
                alu_out      = wide[31:0];
                alu_carry    = wide[32];
                alu_overflow = (alu_a[31] == alu_b[31]) && (alu_out[31] != alu_a[31]);
            end
            3'b001: begin
                alu_out      = alu_a - alu_b;
                alu_carry    = (alu_a >= alu_b);
                alu_overflow = (alu_a[31] != alu_b[31]) && (alu_out[31] != alu_a[31]);
            end
            3'b010:  alu_out = alu_a >> 1;
            3'b011:  alu_out = alu_a << 1;
            3'b100:  alu_out = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            3'b101:  alu_out = alu_a & alu_b;
            3'b110:  alu_out = alu_a | alu_b;
            default: alu_out = alu_a ^ alu_b;
        endcase
    end

    // Offer one command from IDLE, scramble cmd_* after accept, wait for rsp_valid.
    // lat counts cycles from accept (1 = first cycle after the accepting edge).
    task automatic run_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh, input logic [2:0] sel_watch,
                           output int lat, output int sel_hits,
                           output logic [31:0] a1, output logic [31:0] b1, output logic [2:0] sel1);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_shamt = sh; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = ~op; cmd_a = ~a; cmd_b = ~b; cmd_shamt = ~sh;
        a1 = alu_a; b1 = alu_b; sel1 = alu_sel;
        lat = 1; sel_hits = 0;
        while (!rsp_valid && lat < 100) begin
            if (alu_sel == sel_watch) sel_hits++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b1; cmd_op = 3'b000; cmd_a = 32'h1; cmd_b = 32'h1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || alu_sel !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl got rsp_valid=%b busy=%b alu_sel=%b want 0 0 000", rsp_valid, busy, alu_sel);
        end
        checks++;
        if (alu_a !== 32'h0 || alu_b !== 32'h0 || rsp_data !== 32'h0 || rsp_flags !== 4'h0) begin
            errors++; $display("FAIL reset_data got alu_a=%h alu_b=%h data=%h flags=%b want zeros", alu_a, alu_b, rsp_data, rsp_flags);
        end
        cmd_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_release got cmd_ready=%b busy=%b want 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_single(input string name, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] sh,
                               input logic [31:0] exp_data, input logic [3:0] exp_flags, input int exp_lat);
        int lat, hits;
        logic [31:0] a1, b1;
        logic [2:0] sel1;
        run_cmd(op, a, b, sh, op, lat, hits, a1, b1, sel1);
        checks++;
        if (rsp_data !== exp_data || rsp_flags !== exp_flags) begin
            errors++; $display("FAIL %s_result got data=%h flags=%b want data=%h flags=%b", name, rsp_data, rsp_flags, exp_data, exp_flags);
        end
        checks++;
        if (lat != exp_lat) begin
            errors++; $display("FAIL %s_latency got %0d want %0d", name, lat, exp_lat);
        end
        consume_rsp();
    endtask

    task automatic test_add_overflow();
        int lat, hits;
        logic [31:0] a1, b1;
        logic [2:0] sel1;
        run_cmd(3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 5'd9, 3'b000, lat, hits, a1, b1, sel1);
        checks++;
        if (a1 !== 32'h7FFF_FFFF || b1 !== 32'h0000_0001 || sel1 !== 3'b000) begin
            errors++; $display("FAIL add_drive got a=%h b=%h sel=%b want 7fffffff 00000001 000", a1, b1, sel1);
        end
        checks++;
        if (rsp_data !== 32'h8000_0000 || rsp_flags !== 4'b1010 || lat != 2) begin
            errors++; $display("FAIL add_ovf got data=%h flags=%b lat=%0d want 80000000 1010 2", rsp_data, rsp_flags, lat);
        end
        checks++;
        if (alu_sel !== 3'b000 || alu_a !== 32'h0 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
            errors++; $display("FAIL add_resp_state got sel=%b a=%h busy=%b ready=%b want 000 0 1 0", alu_sel, alu_a, busy, cmd_ready);
        end
        consume_rsp();
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL add_return got rsp_valid=%b cmd_ready=%b want 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_shl31();
        int lat, hits;
        logic [31:0] a1, b1;
        logic [2:0] sel1;
        run_cmd(3'b011, 32'h0000_0001, 32'h0000_0005, 5'd31, 3'b011, lat, hits, a1, b1, sel1);
        checks++;
        if (hits != 31 || lat != 32) begin
            errors++; $display("FAIL shl31_timing got sel_cycles=%0d lat=%0d want 31 32", hits, lat);
        end
        checks++;
        if (rsp_data !== 32'h8000_0000 || rsp_flags !== 4'b1000) begin
            errors++; $display("FAIL shl31_result got data=%h flags=%b want 80000000 1000", rsp_data, rsp_flags);
        end
        consume_rsp();
    endtask

    task automatic test_shr_zero();
        int lat, hits;
        logic [31:0] a1, b1;
        logic [2:0] sel1;
        run_cmd(3'b010, 32'h0000_00F0, 32'h0000_0003, 5'd0, 3'b010, lat, hits, a1, b1, sel1);
        checks++;
        if (rsp_data !== 32'h0000_00F0 || rsp_flags !== 4'b0000 || lat != 1) begin
            errors++; $display("FAIL shr0 got data=%h flags=%b lat=%0d want 000000f0 0000 1", rsp_data, rsp_flags, lat);
        end
        checks++;
        if (sel1 !== 3'b000 || alu_sel !== 3'b000) begin
            errors++; $display("FAIL shr0_sel got %b/%b want 000", sel1, alu_sel);
        end
        consume_rsp();
    endtask

    task automatic test_backpressure();
        int lat, hits;
        logic [31:0] a1, b1;
        logic [2:0] sel1;
        run_cmd(3'b000, 32'h0000_0003, 32'h0000_0004, 5'd0, 3'b000, lat, hits, a1, b1, sel1);
        cmd_valid = 1'b1; cmd_op = 3'b111; cmd_a = 32'h0F0F_0000; cmd_b = 32'h00FF_00FF; cmd_shamt = 5'd0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000_0007 || rsp_flags !== 4'b0000 || cmd_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold[%0d] got valid=%b data=%h flags=%b ready=%b want 1 00000007 0000 0", i, rsp_valid, rsp_data, rsp_flags, cmd_ready);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL bp_idle got ready=%b busy=%b valid=%b want 1 0 0", cmd_ready, busy, rsp_valid);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (rsp_data !== 32'h0FF0_00FF || rsp_flags !== 4'b0000 || lat != 2) begin
            errors++; $display("FAIL bp_next got data=%h flags=%b lat=%0d want 0ff000ff 0000 2", rsp_data, rsp_flags, lat);
        end
        consume_rsp();
    endtask

    task automatic test_back_to_back();
        int lat, hits;
        logic [31:0] a1, b1;
        logic [2:0] sel1;
        run_cmd(3'b000, 32'd100, 32'd23, 5'd0, 3'b000, lat, hits, a1, b1, sel1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        run_cmd(3'b001, 32'd100, 32'd23, 5'd0, 3'b001, lat, hits, a1, b1, sel1);
        checks++;
        if (rsp_data !== 32'd77 || rsp_flags !== 4'b0000 || lat != 2) begin
            errors++; $display("FAIL b2b_sub got data=%h flags=%b lat=%0d want 0000004d 0000 2", rsp_data, rsp_flags, lat);
        end
        consume_rsp();
    endtask

    task automatic test_reset_midop();
        int seen;
        cmd_op = 3'b010; cmd_a = 32'hFFFF_0000; cmd_b = 32'h0; cmd_shamt = 5'd20; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || alu_sel !== 3'b010 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL midop_exec got busy=%b sel=%b valid=%b want 1 010 0", busy, alu_sel, rsp_valid);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || alu_sel !== 3'b000 || alu_a !== 32'h0) begin
            errors++; $display("FAIL midop_reset got busy=%b valid=%b sel=%b a=%h want 0 0 000 0", busy, rsp_valid, alu_sel, alu_a);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL midop_release got cmd_ready=%b want 1", cmd_ready);
        end
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (rsp_valid === 1'b1) seen++;
            @(posedge clk); #1;
        end
        checks++;
        if (seen != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL midop_no_rsp got rsp_cycles=%0d busy=%b want 0 0", seen, busy);
        end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_single("sub_zero", 3'b001, 32'd5, 32'd5, 5'd3, 32'h0000_0000, 4'b0100, 2);
        test_shl31();
        test_shr_zero();
        test_single("shr4", 3'b010, 32'h8000_0000, 32'h0000_0001, 5'd4, 32'h0800_0000, 4'b0000, 5);
        test_single("asr", 3'b100, 32'h8000_0000, 32'h0000_0004, 5'd7, 32'hF800_0000, 4'b1000, 2);
        test_single("and", 3'b101, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 32'h00F0_00F0, 4'b0000, 2);
        test_single("or_zero", 3'b110, 32'h0, 32'h0, 5'd0, 32'h0000_0000, 4'b0100, 2);
        test_single("xor", 3'b111, 32'h1234_5678, 32'hFFFF_FFFF, 5'd0, 32'hEDCB_A987, 4'b1000, 2);
        test_single("add_carry", 3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 5'd0, 32'h0000_0001, 4'b0001, 2);
        test_single("sub_wrap", 3'b001, 32'h0, 32'h0000_0001, 5'd0, 32'hFFFF_FFFF, 4'b1000, 2);
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
